// File: rtl/mac_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_pkg
// Brief    : Shared types and helpers for the multiply-accumulate unit.
// Revision : 1.0 - initial release
// ============================================================================
package mac_acc_pkg;

  typedef enum logic [3:0] {
    PASS  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    MADD  = 4'd3,
    MADDU = 4'd4,
    MSUB  = 4'd5,
    MSUBU = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8,
    MFHI  = 4'd9,
    MFLO  = 4'd10
  } acc_op_t;

  localparam logic [3:0] OP_LAST = 4'd10;

  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic n;
  } acc_flags_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// ============================================================================
// Module   : acc_alu
// Brief    : Combinational accumulator datapath: 2W add/sub, result and flags.
//            Optional signed saturation when MAC_ACC_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module acc_alu
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  acc_op_t             op,
  input  logic [2*DATA_W-1:0] acc,
  input  logic [2*DATA_W-1:0] opnd,
  input  acc_flags_t          alu_flags,
  output logic                acc_we,
  output logic [2*DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0]   res,
  output acc_flags_t          flags
);

  localparam int AW = 2 * DATA_W;

  logic              w_sub;
  logic              w_signed;
  logic [AW:0]       w_ext;
  logic [AW-1:0]     w_sum;
  logic [AW-1:0]     w_arith;
  logic              w_ovf;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  assign w_sub    = (op == MSUB) || (op == MSUBU);
  assign w_signed = (op == MADD) || (op == MSUB);
  assign w_hi     = acc[AW-1:DATA_W];
  assign w_lo     = acc[DATA_W-1:0];

  // Zero-extended add/sub: the extra MSB is carry-out for add, borrow for sub
  assign w_ext = w_sub ? ({1'b0, acc} - {1'b0, opnd})
                       : ({1'b0, acc} + {1'b0, opnd});
  assign w_sum = w_ext[AW-1:0];

  // Signs agree (add) or differ (sub) and the result sign flips
  assign w_ovf = ((acc[AW-1] ^ opnd[AW-1]) == w_sub) && (w_sum[AW-1] != acc[AW-1]);

`ifdef MAC_ACC_SAT_EN
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  // Overflow direction follows the sign of the accumulator operand
  assign w_arith = (w_signed && w_ovf) ? (acc[AW-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
  assign w_arith = w_sum;
`endif

  always_comb begin
    acc_we   = 1'b0;
    acc_next = acc;
    res      = opnd[DATA_W-1:0];
    flags    = alu_flags;
    case (op)
      MULT, MULTU: begin
        acc_we   = 1'b1;
        acc_next = opnd;
        flags.c  = 1'b0;
        flags.z  = (opnd == '0);
        flags.o  = 1'b0;
        flags.n  = opnd[AW-1];
      end
      MADD, MADDU, MSUB, MSUBU: begin
        acc_we   = 1'b1;
        acc_next = w_arith;
        res      = w_arith[DATA_W-1:0];
        flags.c  = w_ext[AW];
        flags.z  = (w_arith == '0);
        flags.o  = w_signed & w_ovf;
        flags.n  = w_arith[AW-1];
      end
      MTHI: begin
        acc_we                  = 1'b1;
        acc_next[AW-1:DATA_W]   = opnd[DATA_W-1:0];
      end
      MTLO: begin
        acc_we                  = 1'b1;
        acc_next[DATA_W-1:0]    = opnd[DATA_W-1:0];
      end
      MFHI: begin
        res     = w_hi;
        flags.c = 1'b0;
        flags.z = (w_hi == '0);
        flags.o = 1'b0;
        flags.n = w_hi[DATA_W-1];
      end
      MFLO: begin
        res     = w_lo;
        flags.c = 1'b0;
        flags.z = (w_lo == '0);
        flags.o = 1'b0;
        flags.n = w_lo[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc
// Brief    : Two-stage multiply-accumulate unit with NUM_ACC 2W-bit
//            accumulators. Define MAC_ACC_SAT_EN for signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_acc
  import mac_acc_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int NUM_ACC = 4,
  localparam int SW      = sel_width(NUM_ACC)
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                InValid,
  input  logic                Stall,
  input  acc_op_t             Op,
  input  logic [SW-1:0]       AccSel,
  input  logic [2*DATA_W-1:0] In,
  input  logic                ALUC,
  input  logic                ALUZ,
  input  logic                ALUO,
  input  logic                ALUN,
  output logic                OutValid,
  output logic [DATA_W-1:0]   Out,
  output logic                C,
  output logic                Z,
  output logic                O,
  output logic                N
);

  localparam int AW = 2 * DATA_W;

  // S1 capture stage
  logic          r_s1_valid;
  logic [3:0]    r_s1_op;
  logic [SW-1:0] r_s1_sel;
  logic [AW-1:0] r_s1_in;
  acc_flags_t    r_s1_flags;

  logic [AW-1:0] r_acc [NUM_ACC];

  logic              w_sel_ok;
  logic              w_op_ok;
  acc_op_t           w_op;
  logic [AW-1:0]     w_acc_cur;
  logic              w_acc_we;
  logic [AW-1:0]     w_acc_next;
  logic [DATA_W-1:0] w_res;
  acc_flags_t        w_flags;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_sel   <= '0;
      r_s1_in    <= '0;
      r_s1_flags <= '0;
    end else if (!Stall) begin
      r_s1_valid <= InValid;
      if (InValid) begin
        r_s1_op    <= Op;
        r_s1_sel   <= AccSel;
        r_s1_in    <= In;
        r_s1_flags <= {ALUC, ALUZ, ALUO, ALUN};
      end
    end
  end

  // Unknown opcodes and out-of-range selectors degrade to PASS
  assign w_sel_ok  = (32'(r_s1_sel) < NUM_ACC);
  assign w_op_ok   = (r_s1_op <= OP_LAST);
  assign w_op      = (w_op_ok && w_sel_ok) ? acc_op_t'(r_s1_op) : PASS;
  assign w_acc_cur = w_sel_ok ? r_acc[r_s1_sel] : '0;

  acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op        (w_op),
    .acc       (w_acc_cur),
    .opnd      (r_s1_in),
    .alu_flags (r_s1_flags),
    .acc_we    (w_acc_we),
    .acc_next  (w_acc_next),
    .res       (w_res),
    .flags     (w_flags)
  );

  // S2 result stage; the accumulator write shares this edge so the next op
  // in S1 already reads the updated value
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      OutValid <= 1'b0;
      Out      <= '0;
      C        <= 1'b0;
      Z        <= 1'b0;
      O        <= 1'b0;
      N        <= 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
        r_acc[i] <= '0;
      end
    end else if (!Stall) begin
      OutValid <= r_s1_valid;
      if (r_s1_valid) begin
        Out <= w_res;
        C   <= w_flags.c;
        Z   <= w_flags.z;
        O   <= w_flags.o;
        N   <= w_flags.n;
        if (w_acc_we) begin
          r_acc[r_s1_sel] <= w_acc_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_acc
// Brief    : Scoreboard bench for mac_acc (W=32, NUM_ACC=4); honours
//            MAC_ACC_SAT_EN for the saturation expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_acc;
  import mac_acc_pkg::*;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic signed [64:0] SMAX = {1'b0, MAXP};
  localparam logic signed [64:0] SMIN = {1'b1, MINN};

  logic        clk     = 1'b0;
  logic        nReset  = 1'b0;
  logic        InValid = 1'b0;
  logic        Stall   = 1'b0;
  acc_op_t     Op      = PASS;
  logic [1:0]  AccSel  = 2'd0;
  logic [63:0] In      = 64'd0;
  logic        ALUC = 1'b0, ALUZ = 1'b0, ALUO = 1'b0, ALUN = 1'b0;
  logic        OutValid;
  logic [31:0] Out;
  logic        C, Z, O, N;

  typedef struct {
    logic [31:0] out;
    logic [3:0]  f;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [63:0] macc [4];
  logic [31:0] last_out = 32'd0;
  logic [3:0]  last_f   = 4'd0;
  int          ucnt   = 0;
  int          checks = 0;
  int          errors = 0;

  mac_acc #(.DATA_W(32), .NUM_ACC(4)) dut (
    .Clock(clk), .nReset(nReset), .InValid(InValid), .Stall(Stall),
    .Op(Op), .AccSel(AccSel), .In(In),
    .ALUC(ALUC), .ALUZ(ALUZ), .ALUO(ALUO), .ALUN(ALUN),
    .OutValid(OutValid), .Out(Out), .C(C), .Z(Z), .O(O), .N(N)
  );

  always #5 clk = ~clk;

  // Unstalled, out-of-reset cycle counter used to time results
  initial forever begin
    @(posedge clk);
    if (nReset && !Stall) ucnt++;
  end

  initial forever begin
    @(negedge clk);
    if (nReset) begin
      checks++;
      if (OutValid === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: OutValid=1 Out=%h with no result pending", Out);
        end else begin
          me = q.pop_front();
          if (Out !== me.out || {C, Z, O, N} !== me.f || ucnt != me.due) begin
            errors++;
            $display("FAIL result: got Out=%h CZON=%b cycle %0d, want Out=%h CZON=%b cycle %0d",
                     Out, {C, Z, O, N}, ucnt, me.out, me.f, me.due);
          end
          last_out = me.out;
          last_f   = me.f;
        end
      end else if (Out !== last_out || {C, Z, O, N} !== last_f) begin
        errors++;
        $display("FAIL hold: got Out=%h CZON=%b, want Out=%h CZON=%b",
                 Out, {C, Z, O, N}, last_out, last_f);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  task automatic model_push(input logic [3:0] op, input logic [1:0] sel,
                            input logic [63:0] x, input logic [3:0] f);
    exp_t              e;
    logic [63:0]       a;
    logic [64:0]       u;
    logic signed [64:0] s;
    logic [63:0]       r;
    logic              ov;
    logic              sgn;
    a     = macc[sel];
    e.out = x[31:0];
    e.f   = f;
    case (op)
      4'd1, 4'd2: begin
        macc[sel] = x;
        e.f = {1'b0, (x == 64'd0), 1'b0, x[63]};
      end
      4'd3, 4'd4, 4'd5, 4'd6: begin
        sgn = (op == 4'd3) || (op == 4'd5);
        if (op == 4'd3 || op == 4'd4) begin
          u = {1'b0, a} + {1'b0, x};
          s = $signed({a[63], a}) + $signed({x[63], x});
        end else begin
          u = {1'b0, a} - {1'b0, x};
          s = $signed({a[63], a}) - $signed({x[63], x});
        end
        ov = (s > SMAX) || (s < SMIN);
        r  = u[63:0];
`ifdef MAC_ACC_SAT_EN
        if (sgn && ov) r = (s < 0) ? MINN : MAXP;
`endif
        macc[sel] = r;
        e.out = r[31:0];
        e.f   = {u[64], (r == 64'd0), sgn & ov, r[63]};
      end
      4'd7: macc[sel][63:32] = x[31:0];
      4'd8: macc[sel][31:0]  = x[31:0];
      4'd9: begin
        e.out = a[63:32];
        e.f   = {1'b0, (a[63:32] == 32'd0), 1'b0, a[63]};
      end
      4'd10: begin
        e.out = a[31:0];
        e.f   = {1'b0, (a[31:0] == 32'd0), 1'b0, a[31]};
      end
      default: ;
    endcase
    e.due = ucnt + 2;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] sel,
                       input logic [63:0] x, input logic [3:0] f);
    Op      = acc_op_t'(op);
    AccSel  = sel;
    In      = x;
    {ALUC, ALUZ, ALUO, ALUN} = f;
    InValid = 1'b1;
    model_push(op, sel, x, f);
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, want 0", q.size());
      q.delete();
    end
    idle(1);
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) macc[i] = 64'd0;
    last_out = 32'd0;
    last_f   = 4'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    #12;
    checks++;
    if ({OutValid, Out, C, Z, O, N} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got OutValid=%b Out=%h CZON=%b, want all 0",
               OutValid, Out, {C, Z, O, N});
    end
    #1 nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(MFLO, 2'(i), 64'd0, 4'd0);
      issue(MFHI, 2'(i), 64'd0, 4'd0);
    end
    drain();
  endtask

  task automatic test_mult_mfhi();
    issue(MULT, 2'd0, 64'h0000_0001_0000_0005, 4'd0);
    issue(MFHI, 2'd0, 64'd0, 4'd0);
    checks++;
    if (OutValid !== 1'b1 || Out !== 32'd5 || Z !== 1'b0 || N !== 1'b0) begin
      errors++;
      $display("FAIL mult_out: got OutValid=%b Out=%h Z=%b N=%b, want 1 00000005 0 0",
               OutValid, Out, Z, N);
    end
    idle(1);
    checks++;
    if (Out !== 32'd1) begin
      errors++;
      $display("FAIL mfhi_out: got Out=%h, want 00000001", Out);
    end
    drain();
  endtask

  task automatic test_maddu_carry();
    issue(MTHI, 2'd1, 64'hFFFF_FFFF, 4'b0100);
    issue(MTLO, 2'd1, 64'hFFFF_FFFF, 4'b1001);
    issue(MADDU, 2'd1, 64'd1, 4'd0);
    idle(1);
    checks++;
    if (Out !== 32'd0 || {C, Z, O} !== 3'b110) begin
      errors++;
      $display("FAIL maddu_carry: got Out=%h CZO=%b, want 00000000 110", Out, {C, Z, O});
    end
    issue(MFHI, 2'd1, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_madd_ovf();
    logic [33:0] want;
`ifdef MAC_ACC_SAT_EN
    want = {32'hFFFF_FFFF, 2'b10};
`else
    want = {32'h0000_0000, 2'b11};
`endif
    issue(MTHI, 2'd2, 64'h7FFF_FFFF, 4'd0);
    issue(MTLO, 2'd2, 64'hFFFF_FFFF, 4'd0);
    issue(MADD, 2'd2, 64'd1, 4'd0);
    idle(1);
    checks++;
    if ({Out, O, N} !== want) begin
      errors++;
      $display("FAIL madd_ovf: got Out=%h O=%b N=%b, want Out=%h O=%b N=%b",
               Out, O, N, want[33:2], want[1], want[0]);
    end
    issue(MFHI, 2'd2, 64'd0, 4'd0);
    issue(MFLO, 2'd2, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) issue(MADD, 2'd3, 64'd3, 4'd0);
    checks++;
    if (Out !== 32'd6) begin
      errors++;
      $display("FAIL b2b_second: got Out=%h, want 00000006", Out);
    end
    idle(1);
    checks++;
    if (Out !== 32'd9) begin
      errors++;
      $display("FAIL b2b_third: got Out=%h, want 00000009", Out);
    end
    issue(MFLO, 2'd0, 64'd0, 4'd0);
    issue(MFHI, 2'd0, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_msub();
    issue(MULT, 2'd3, 64'd0, 4'd0);
    issue(MSUBU, 2'd3, 64'd1, 4'd0);
    issue(MULT, 2'd3, MINN, 4'd0);
    issue(MSUB, 2'd3, 64'd1, 4'd0);
    idle(1);
    checks++;
    if (O !== 1'b1 || C !== 1'b0) begin
      errors++;
      $display("FAIL msub_ovf: got O=%b C=%b, want O=1 C=0", O, C);
    end
    issue(MSUB, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
    issue(MFHI, 2'd3, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_pass_undef();
    issue(PASS, 2'd0, 64'hAAAA_BBBB_1234_5678, 4'b1010);
    idle(1);
    checks++;
    if (Out !== 32'h1234_5678 || {C, Z, O, N} !== 4'b1010) begin
      errors++;
      $display("FAIL pass: got Out=%h CZON=%b, want 12345678 1010", Out, {C, Z, O, N});
    end
    issue(4'd12, 2'd2, 64'h0123_4567_FFFF_0000, 4'b0101);
    issue(4'd15, 2'd1, 64'h0000_0000_0000_0000, 4'b1111);
    issue(MFLO, 2'd2, 64'd0, 4'd0);
    issue(MFLO, 2'd1, 64'd0, 4'd0);
    issue(MTHI, 2'd0, 64'h5555_5555_CAFE_0000, 4'b0110);
    issue(MFHI, 2'd0, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_stall();
    issue(MULT, 2'd3, 64'd100, 4'd0);
    drain();
    issue(MADD, 2'd3, 64'h10, 4'd0);
    Stall   = 1'b1;
    InValid = 1'b1;
    Op      = MULT;
    AccSel  = 2'd0;
    In      = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got OutValid=%b in stall cycle %0d, want 0", OutValid, i);
      end
    end
    Stall   = 1'b0;
    InValid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b1 || Out !== 32'h74) begin
      errors++;
      $display("FAIL stall_release: got OutValid=%b Out=%h, want 1 00000074", OutValid, Out);
    end
    issue(MFLO, 2'd3, 64'd0, 4'd0);
    issue(MFLO, 2'd0, 64'd0, 4'd0);
    drain();
  endtask

  task automatic test_reset_inflight();
    issue(MULT, 2'd1, 64'h0ABC, 4'd0);
    issue(MADD, 2'd1, 64'd7, 4'd0);
    #2;
    apply_reset();
    #1;
    checks++;
    if ({OutValid, Out, C, Z, O, N} !== 37'd0) begin
      errors++;
      $display("FAIL reset_async: got OutValid=%b Out=%h CZON=%b, want all 0",
               OutValid, Out, {C, Z, O, N});
    end
    #2 nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(MFLO, 2'(i), 64'd0, 4'd0);
      issue(MFHI, 2'(i), 64'd0, 4'd0);
    end
    drain();
  endtask

  task automatic test_random();
    logic [63:0] x;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(4))
          0:       x = 64'd0;
          1:       x = MAXP;
          2:       x = MINN;
          3:       x = {32'd0, $urandom};
          default: x = {$urandom, $urandom};
        endcase
        issue(4'($urandom_range(15)), 2'($urandom_range(3)), x, 4'($urandom_range(15)));
      end
    end
    for (int i = 0; i < 4; i++) begin
      issue(MFHI, 2'(i), 64'd0, 4'd0);
      issue(MFLO, 2'(i), 64'd0, 4'd0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_mult_mfhi();
    test_maddu_carry();
    test_madd_ovf();
    test_back_to_back();
    test_msub();
    test_pass_undef();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
